// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned PC_MAX_W         = 64;
    localparam int unsigned INSTR_WORD_BYTES = 4;

    // pc is stored zero-extended so one entry type serves every XLEN up to 64.
    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         instr;
        logic                filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular buffer of fetch entries: allocated on request, filled in order by
// memory responses, popped from the head by decode, cleared on flush.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_alloc,
    input  logic [XLEN-1:0]        i_allocPc,
    input  logic                   i_fill,
    input  logic [31:0]            i_fillData,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic                   o_headFilled,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [$clog2(DEPTH):0] o_unfilled
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_fill;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_unfilled;

    assign o_head       = r_entries[r_head];
    assign o_headFilled = (r_count != '0) && r_entries[r_head].filled;
    assign o_count      = r_count;
    assign o_unfilled   = r_unfilled;

    // Fill never targets the tail slot: that would need zero or DEPTH unfilled entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
        end else if (i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
        end else begin
            if (i_alloc) begin
                r_entries[r_tail] <= '{pc: PC_MAX_W'(i_allocPc), instr: 32'h0, filled: 1'b0};
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (i_fill) begin
                r_entries[r_fill].instr  <= i_fillData;
                r_entries[r_fill].filled <= 1'b1;
                r_fill                   <= r_fill + PTR_W'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count    <= r_count + CNT_W'(i_alloc) - CNT_W'(i_pop);
            r_unfilled <= r_unfilled + CNT_W'(i_alloc) - CNT_W'(i_fill);
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC sequencing, credit-limited memory requests, stale
// response dropping after redirects, and an in-order buffer toward decode.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic             r_started;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_dropCnt;

    fetch_entry_t     w_head;
    logic             w_headFilled;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_unfilled;
    logic [CNT_W:0]   w_inUse;
    logic             w_credit;
    logic             w_reqFire;
    logic             w_pop;
    logic             w_drop;
    logic             w_fill;
    logic             w_unusedHead;

    // Outstanding stale responses still occupy credit so every response has a home.
    assign w_inUse          = {1'b0, w_count} + {1'b0, r_dropCnt};
    assign w_credit         = w_inUse < (CNT_W + 1)'(DEPTH);
    assign imem_req_valid_o = r_started && !redirect_valid_i && w_credit;
    assign imem_req_addr_o  = r_pc;
    assign w_reqFire        = imem_req_valid_o && imem_req_ready_i;

    assign valid_o      = w_headFilled && !redirect_valid_i;
    assign instr_o      = w_head.instr;
    assign pc_o         = w_head.pc[XLEN-1:0];
    assign w_pop        = valid_o && ready_i;
    assign w_unusedHead = &{1'b0, w_head};

    assign w_drop = imem_rsp_valid_i && (r_dropCnt != '0);
    assign w_fill = imem_rsp_valid_i && !w_drop && !redirect_valid_i;

    // A response in a redirect cycle retires either a drop credit or an unfilled slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_started <= 1'b0;
            r_pc      <= RESET_PC & ALIGN_MASK;
            r_dropCnt <= '0;
        end else begin
            r_started <= 1'b1;
            if (redirect_valid_i) begin
                r_pc      <= redirect_pc_i & ALIGN_MASK;
                r_dropCnt <= r_dropCnt + w_unfilled - CNT_W'(imem_rsp_valid_i);
            end else begin
                if (w_reqFire) begin
                    r_pc <= r_pc + XLEN'(INSTR_WORD_BYTES);
                end
                if (w_drop) begin
                    r_dropCnt <= r_dropCnt - CNT_W'(1);
                end
            end
        end
    end

    fetch_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_buffer (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_alloc      (w_reqFire),
        .i_allocPc    (r_pc),
        .i_fill       (w_fill),
        .i_fillData   (imem_rsp_data_i),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid_i),
        .o_head       (w_head),
        .o_headFilled (w_headFilled),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled)
    );

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, fetch buffer entries, power of two, >=2.
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 redirect_valid_i  input  1  flush and restart fetch (branch/jump/trap).
REQ-007 redirect_pc_i  input  XLEN  new fetch PC.
REQ-008 imem_req_valid_o  output  1  instruction memory request valid.
REQ-009 imem_req_ready_i  input  1  memory accepts request.
REQ-010 imem_req_addr_o  output  XLEN  request word address.
REQ-011 imem_rsp_valid_i  input  1  response valid; in request order; no backpressure.
REQ-012 imem_rsp_data_i  input  32  fetched instruction word.
REQ-013 valid_o  output  1  instruction available to decode.
REQ-014 ready_i  input  1  decode accepts instruction.
REQ-015 instr_o  output  32  instruction word.
REQ-016 pc_o  output  XLEN  PC of instr_o.

Function
REQ-017 Fetch PC register holds next address; imem_req_addr_o = fetch PC, bits [1:0] always 0.
REQ-018 Request handshake = imem_req_valid_o & imem_req_ready_i; on it fetch PC += 4 (wraps modulo 2^XLEN) and one buffer entry is allocated holding the PC, marked unfilled.
REQ-019 imem_req_valid_o = started & !redirect_valid_i & (allocated entries + drop_cnt < DEPTH); credit check guarantees every response has a destination.
REQ-020 Response fills the oldest unfilled entry (fill pointer) with imem_rsp_data_i, unless drop_cnt > 0, in which case it is discarded and drop_cnt decrements.
REQ-021 valid_o = head entry filled & !redirect_valid_i; instr_o/pc_o driven from head entry; head pops on valid_o & ready_i.
REQ-022 valid_o, instr_o, pc_o held stable while valid_o & !ready_i, absent redirect.
REQ-023 Latency: response in cycle N presents valid_o in cycle N+1 when buffer ahead is empty.
REQ-024 Allocate, fill and pop may all occur in one cycle; full buffer (DEPTH allocated) blocks requests only, pop in the same cycle frees credit next cycle.
REQ-025 Redirect: all entries cleared; fetch PC <= {redirect_pc_i[XLEN-1:2], 2'b00}; drop_cnt <= drop_cnt + (allocated unfilled entries) - (1 if response consumed that cycle by a filled-slot or drop).
REQ-026 Redirect cycle: no request handshake, no pop; a response arriving that cycle is treated as stale and discarded.
REQ-027 Back-to-back redirects accumulate drop_cnt; drop_cnt width = clog2(DEPTH)+1, never exceeds DEPTH.
REQ-028 New requests may issue the cycle after a redirect, subject to REQ-019.
REQ-029 Memory may observe imem_req_valid_o withdrawn without handshake only in a redirect cycle.

Reset
REQ-030 While rst_ni low: fetch PC = RESET_PC, buffer empty, pointers 0, drop_cnt 0, started 0.
REQ-031 Outputs during reset: imem_req_valid_o 0, valid_o 0, instr_o 0, pc_o 0, imem_req_addr_o RESET_PC.
REQ-032 started sets on the first clock edge after rst_ni deasserts; first request may be issued the following cycle.
REQ-033 Reset asserted mid-operation discards all in-flight and buffered state immediately; responses from pre-reset requests are the memory's responsibility to cancel.

Structure
REQ-034 fetch_pkg holds fetch_entry_t {pc, instr, filled} and INSTR_WORD_BYTES constant; decode_pkg unchanged.
REQ-035 One sub-module fetch_buffer (DEPTH-entry circular buffer with alloc, fill, pop, flush ports); credit, drop counter and PC logic stay in fetch.

Verification
REQ-036 Reset release, imem always ready, 1-cycle response, ready_i=1 -> requests at 0x0,0x4,0x8,...; decode sees matching pc_o/instr_o in order, one per cycle steady state.
REQ-037 ready_i=0 for 10 cycles -> exactly DEPTH(4) requests issued then imem_req_valid_o low; valid_o/instr_o/pc_o 0x0 stable; on ready_i=1 drain 0x0..0xC in order.
REQ-038 3 requests outstanding (0x10,0x14,0x18), redirect to 0x103 -> next request addr 0x100; three following responses dropped; first valid_o has pc_o 0x100.
REQ-039 Redirect in same cycle as a response with 2 outstanding -> response dropped, drop_cnt=1; next response dropped, following one delivered with redirected PC.
REQ-040 Two consecutive redirect cycles (0x200 then 0x300) with 2 outstanding -> only 0x300 stream reaches decode, no stale instruction ever presented.
REQ-041 rst_ni asserted with full buffer and valid_o high -> valid_o and imem_req_valid_o low asynchronously; after release fetch restarts at RESET_PC.
